// File: rtl/instr_issuer_if.sv
// Instruction-issuer bus: program load port, run control, processor
// instruction/result handshake and run statistics.
interface instr_issuer_if #(parameter int AW = 4);
  // program load and run control
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [9:0]    prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  // instruction to processor
  logic [1:0]    opcode;
  logic [3:0]    reg_a;
  logic [3:0]    reg_b;
  logic          issue_valid;
  // result from processor
  logic [3:0]    result;
  logic          zero_flag;
  // run status
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [3:0]    last_result;
  logic [AW:0]   zero_count;
  logic [7:0]    result_sum;

  modport master (
    input  prog_we, prog_addr, prog_data, prog_len, start, result, zero_flag,
    output opcode, reg_a, reg_b, issue_valid, pc, busy, done,
           last_result, zero_count, result_sum
  );

  modport slave (
    output prog_we, prog_addr, prog_data, prog_len, start, result, zero_flag,
    input  opcode, reg_a, reg_b, issue_valid, pc, busy, done,
           last_result, zero_count, result_sum
  );
endinterface

// File: rtl/instr_issuer.sv
// Instruction-issuing front end: loadable program memory plus a
// fetch/issue/capture loop that drives the 4-bit processor and gathers
// its results into simple run statistics.
module instr_issuer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  instr_issuer_if.master io_bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [9:0]    r_mem [DEPTH];
  logic [9:0]    r_ir;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_last;       // pc of the final instruction of this run
  logic [3:0]    r_last_result;
  logic [AW:0]   r_zero_count;
  logic [7:0]    r_sum;

  logic [AW:0]   w_len;
  logic [AW:0]   w_len_m1;
  logic          w_busy;

  // Effective run length: anything beyond the memory is clamped to DEPTH.
  assign w_len    = (io_bus.prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : io_bus.prog_len;
  assign w_len_m1 = w_len - (AW+1)'(1);
  assign w_busy   = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_CAPTURE);

  // State register; async reset abandons any run in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (io_bus.start) w_next = (w_len == '0) ? S_DONE : S_FETCH;
      S_FETCH:   w_next = S_ISSUE;
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = (r_pc == r_last) ? S_DONE : S_FETCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Program memory write port; locked out while a run is active, never reset.
  always_ff @(posedge i_clk) begin
    if (io_bus.prog_we && !w_busy) r_mem[io_bus.prog_addr] <= io_bus.prog_data;
  end

  // Datapath: run setup, instruction fetch and result capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ir          <= '0;
      r_pc          <= '0;
      r_last        <= '0;
      r_last_result <= '0;
      r_zero_count  <= '0;
      r_sum         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // zero-length start leaves the previous statistics untouched
          if (io_bus.start && (w_len != '0)) begin
            r_pc         <= '0;
            r_last       <= w_len_m1[AW-1:0];
            r_zero_count <= '0;
            r_sum        <= '0;
          end
        end
        S_FETCH: r_ir <= r_mem[r_pc];
        S_CAPTURE: begin
          r_last_result <= io_bus.result;
          r_sum         <= r_sum + {4'b0000, io_bus.result};
          if (io_bus.zero_flag) r_zero_count <= r_zero_count + (AW+1)'(1);
          // pc parks on the last instruction instead of wrapping
          if (r_pc != r_last) r_pc <= r_pc + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Operand fields come straight from the instruction register, so they
  // stay put through CAPTURE and after the run.
  assign io_bus.opcode      = r_ir[9:8];
  assign io_bus.reg_a       = r_ir[7:4];
  assign io_bus.reg_b       = r_ir[3:0];
  assign io_bus.issue_valid = (r_state == S_ISSUE);
  assign io_bus.busy        = w_busy;
  assign io_bus.done        = (r_state == S_DONE);
  assign io_bus.pc          = r_pc;
  assign io_bus.last_result = r_last_result;
  assign io_bus.zero_count  = r_zero_count;
  assign io_bus.result_sum  = r_sum;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer with a registered 4-bit ALU model
// standing in for the processor.
module tb_instr_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  instr_issuer_if #(.AW(4)) bus ();

  instr_issuer #(.DEPTH(16), .AW(4)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  always #5 clk = ~clk;

  // processor model: result and zero flag registered on the ISSUE edge
  always @(posedge clk) begin
    if (bus.issue_valid) begin
      logic [3:0] r;
      case (bus.opcode)
        2'b00:   r = bus.reg_a + bus.reg_b;
        2'b01:   r = bus.reg_a - bus.reg_b;
        2'b10:   r = bus.reg_a & bus.reg_b;
        default: r = bus.reg_a | bus.reg_b;
      endcase
      bus.result    <= r;
      bus.zero_flag <= (r == 4'd0);
    end
  end

  logic [3:0] caps[$];
  int         n_iss, n_done, dcyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".opcode"},  32'(bus.opcode), 0);
    chk({tag, ".reg_a"},   32'(bus.reg_a), 0);
    chk({tag, ".reg_b"},   32'(bus.reg_b), 0);
    chk({tag, ".iv"},      32'(bus.issue_valid), 0);
    chk({tag, ".pc"},      32'(bus.pc), 0);
    chk({tag, ".busy"},    32'(bus.busy), 0);
    chk({tag, ".done"},    32'(bus.done), 0);
    chk({tag, ".last"},    32'(bus.last_result), 0);
    chk({tag, ".zcnt"},    32'(bus.zero_count), 0);
    chk({tag, ".sum"},     32'(bus.result_sum), 0);
  endtask

  task automatic prog(input int addr, input logic [9:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(addr);
    bus.prog_data = data;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  // Pulse start, then observe cycles 1..bound after the start edge.
  // Optional extra start pulses (inj1/inj2) and a write attempt (wr_at).
  task automatic do_run(input int bound, input int inj1, input int inj2, input int wr_at);
    logic [1:0] iv_h;
    iv_h = 2'b00;
    caps.delete();
    n_iss = 0; n_done = 0; dcyc = -1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= bound; k++) begin
      if (k > 1) tick();
      if (iv_h[1]) caps.push_back(bus.last_result);
      if (bus.issue_valid) n_iss++;
      if (bus.done) begin
        n_done++;
        if (dcyc < 0) dcyc = k;
      end
      iv_h = {iv_h[0], bus.issue_valid};
      bus.start   = (k == inj1) || (k == inj2);
      bus.prog_we = (k == wr_at);
      if (k == wr_at) begin
        bus.prog_addr = 4'd0;
        bus.prog_data = 10'h0FF;
      end
    end
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
  endtask

  task automatic chk_s2(input string tag);
    chk({tag, ".ncap"}, caps.size(), 4);
    if (caps.size() == 4) begin
      chk({tag, ".r0"}, 32'(caps[0]), 7);
      chk({tag, ".r1"}, 32'(caps[1]), 0);
      chk({tag, ".r2"}, 32'(caps[2]), 8);
      chk({tag, ".r3"}, 32'(caps[3]), 3);
    end
    chk({tag, ".zcnt"},  32'(bus.zero_count), 1);
    chk({tag, ".sum"},   32'(bus.result_sum), 18);
    chk({tag, ".last"},  32'(bus.last_result), 3);
    chk({tag, ".pc"},    32'(bus.pc), 3);
    chk({tag, ".dcyc"},  dcyc, 13);
    chk({tag, ".ndone"}, n_done, 1);
    chk({tag, ".niss"},  n_iss, 4);
    chk({tag, ".op"},    32'({bus.opcode, bus.reg_a, bus.reg_b}), 32'h312);
  endtask

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.prog_len = '0;  bus.start = 1'b0;
    bus.result = '0;    bus.zero_flag = 1'b0;

    // reset while idle
    tick(); tick();
    chk_zero("rst");
    rst = 1'b0;
    tick();
    chk_zero("post_rst");

    // zero-length run: immediate done, nothing issued
    bus.prog_len = 5'd0;
    do_run(6, 0, 0, 0);
    chk("len0.dcyc",  dcyc, 1);
    chk("len0.ndone", n_done, 1);
    chk("len0.niss",  n_iss, 0);
    chk("len0.zcnt",  32'(bus.zero_count), 0);
    chk("len0.sum",   32'(bus.result_sum), 0);
    chk("len0.pc",    32'(bus.pc), 0);

    // four-instruction program
    prog(0, {2'b00, 4'h3, 4'h4});
    prog(1, {2'b01, 4'h5, 4'h5});
    prog(2, {2'b10, 4'hC, 4'hA});
    prog(3, {2'b11, 4'h1, 4'h2});
    bus.prog_len = 5'd4;
    do_run(20, 0, 0, 0);
    chk_s2("s2");

    // start during CAPTURE and DONE ignored; write during busy dropped
    do_run(30, 3, 13, 2);
    chk_s2("s6");

    // reset during ISSUE of the second instruction
    do_run(5, 0, 0, 0);
    chk("s5.iv", 32'(bus.issue_valid), 1);
    chk("s5.op", 32'(bus.opcode), 1);
    rst = 1'b1;
    #1;
    chk_zero("s5.rst");
    tick();
    rst = 1'b0;
    tick();
    do_run(20, 0, 0, 0);
    chk_s2("s5.rerun");

    // full-depth run of F+F
    for (int a = 0; a < 16; a++) prog(a, {2'b00, 4'hF, 4'hF});
    bus.prog_len = 5'd16;
    do_run(60, 0, 0, 0);
    chk("s4.ncap",  caps.size(), 16);
    chk("s4.allE",  int'(caps.size() == 16 && caps.sum() with (int'(item == 4'hE)) == 16), 1);
    chk("s4.sum",   32'(bus.result_sum), 224);
    chk("s4.zcnt",  32'(bus.zero_count), 0);
    chk("s4.pc",    32'(bus.pc), 15);
    chk("s4.dcyc",  dcyc, 49);
    chk("s4.ndone", n_done, 1);

    // oversize length clamps to the full memory
    bus.prog_len = 5'd20;
    do_run(60, 0, 0, 0);
    chk("clamp.niss", n_iss, 16);
    chk("clamp.sum",  32'(bus.result_sum), 224);
    chk("clamp.pc",   32'(bus.pc), 15);
    chk("clamp.dcyc", dcyc, 49);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
Instruction-issuing front end for the 4-bit mini processor. It holds a small loadable program memory and runs a fetch-issue-capture loop. Each cycle of the loop drives opcode, reg_a and reg_b into the processor, then collects result and zero_flag back. It is the initiator end of the processor's instruction interface and replaces bench-driven stimulus with a self-sequenced program run.

Parameters:
DEPTH, 16, number of program words (power of 2).
AW, 4, program address width (log2 DEPTH).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
prog_we  input  1  program write strobe; ignored while busy=1
prog_addr  input  AW  program write address
prog_data  input  10  instruction word: [9:8] opcode, [7:4] reg_a, [3:0] reg_b
prog_len  input  AW+1  number of instructions to run; values > DEPTH are clamped to DEPTH
start  input  1  begin run at pc=0; sampled only in IDLE
opcode  output  2  opcode to processor
reg_a  output  4  operand A to processor
reg_b  output  4  operand B to processor
issue_valid  output  1  high in the ISSUE state only
result  input  4  processor ALU result (registered in processor, valid the cycle after ISSUE)
zero_flag  input  1  processor zero flag, same timing as result
pc  output  AW  index of the current instruction
busy  output  1  high in FETCH, ISSUE and CAPTURE
done  output  1  one-cycle pulse at end of run
last_result  output  4  most recently captured result
zero_count  output  AW+1  number of captured results with zero_flag=1 in the current run
result_sum  output  8  sum of captured results, modulo 256, for the current run

Behaviour:
- Reset (asynchronous, active-high): state=IDLE.
  - All outputs are 0: opcode, reg_a, reg_b, issue_valid, pc, busy, done, last_result, zero_count, result_sum.
  - Program memory contents are not cleared.
- Program write: on a clock edge with prog_we=1 and busy=0, mem[prog_addr] <= prog_data. Writes while busy=1 are dropped.
- FSM states: IDLE, FETCH, ISSUE, CAPTURE, DONE.
  - IDLE, start=1, effective length L=0: go to DONE. No instruction is issued.
  - IDLE, start=1, L>0: pc<=0, zero_count<=0, result_sum<=0; go to FETCH.
  - FETCH: instruction register <= mem[pc]; go to ISSUE.
  - ISSUE:
    - opcode, reg_a, reg_b are driven from the instruction register; issue_valid=1.
    - Go to CAPTURE.
    - The operand fields stay stable through CAPTURE.
  - CAPTURE:
    - last_result <= result.
    - result_sum <= result_sum + result, modulo 256.
    - If zero_flag=1, zero_count <= zero_count + 1.
    - If pc == L-1, go to DONE; otherwise pc <= pc+1 and go to FETCH.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Cycle counts:
  - Each instruction takes 3 cycles.
  - A run of L instructions raises done 3L+1 cycles after the start edge.
- Hold behaviour:
  - start while busy or in DONE is ignored. No restart or queuing.
  - After a run, pc, last_result, zero_count and result_sum hold their values until the next start.
  - opcode, reg_a and reg_b keep their last values after the run.
- L=DEPTH: pc reaches DEPTH-1 and does not wrap. The run ends in DONE.
- Reset asserted mid-run: the machine returns to IDLE immediately and any in-flight capture is discarded.
- Opcode encoding (passed through unchanged, fixed by the processor): 00 ADD, 01 SUB, 10 AND, 11 OR.

Test Plan:
1. Reset during an idle period → all outputs 0 and busy=0. Program 4 words, then check that a write attempted while busy leaves mem unchanged.
2. Program {00,3,4}, {01,5,5}, {10,C,A}, {11,1,2}, prog_len=4, start, with the processor model attached → captured results 7, 0, 8, 3; zero_count=1; result_sum=18; last_result=3; done pulses 13 cycles after start for one cycle.
3. prog_len=0 with start → done pulses 1 cycle after start; issue_valid never rises; counters remain 0.
4. Program 16 words of {00,F,F}, prog_len=16 → results are all E; result_sum=224; pc ends at 15 without wrapping; done is asserted after 49 cycles.
5. Assert reset during ISSUE of instruction 2 in scenario 2 → immediate IDLE with all outputs 0. A restart reproduces the scenario 2 results exactly.
6. Pulse start during CAPTURE and during DONE → ignored; exactly one run completes and exactly one done pulse occurs.
